// File: rtl/newmot_wb_pkg.sv
// Shared types and defaults for the newmot two-master Wishbone arbiter.
package newmot_wb_pkg;

    localparam int NEWMOT_WB_ADR_W_DEFAULT   = 30;
    localparam int NEWMOT_WB_DAT_W_DEFAULT   = 32;
    localparam int NEWMOT_WB_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_ERR  = 2'd2
    } wb_state_e;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } wb_owner_e;

    // A zero limit still needs a one-bit counter so the port widths stay legal.
    function automatic int wd_cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/newmot_wb_watchdog.sv
// Saturating stall counter; expired is high while the count sits at LIMIT.
module newmot_wb_watchdog
    import newmot_wb_pkg::*;
#(
    parameter int LIMIT = NEWMOT_WB_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int              CNT_W   = wd_cnt_width(LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
    localparam bit              ENABLED = (LIMIT != 0);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT_C)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = ENABLED && (cnt == LIMIT_C);

endmodule

// File: rtl/newmot_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter, locked per bus cycle, with a
// per-transfer watchdog that forces an error termination on a silent slave.
module newmot_wb_arbiter
    import newmot_wb_pkg::*;
#(
    parameter int ADR_W   = NEWMOT_WB_ADR_W_DEFAULT,
    parameter int DAT_W   = NEWMOT_WB_DAT_W_DEFAULT,
    parameter int TIMEOUT = NEWMOT_WB_TIMEOUT_DEFAULT
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,

    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic             m0_we,
    input  logic [3:0]       m0_sel,
    input  logic [ADR_W-1:0] m0_adr,
    input  logic [DAT_W-1:0] m0_dat_w,
    output logic [DAT_W-1:0] m0_dat_r,
    output logic             m0_ack,
    output logic             m0_err,

    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic             m1_we,
    input  logic [3:0]       m1_sel,
    input  logic [ADR_W-1:0] m1_adr,
    input  logic [DAT_W-1:0] m1_dat_w,
    output logic [DAT_W-1:0] m1_dat_r,
    output logic             m1_ack,
    output logic             m1_err,

    output logic             s_cyc,
    output logic             s_stb,
    output logic             s_we,
    output logic [3:0]       s_sel,
    output logic [ADR_W-1:0] s_adr,
    output logic [DAT_W-1:0] s_dat_w,
    input  logic [DAT_W-1:0] s_dat_r,
    input  logic             s_ack,

    output logic [1:0]       grant
);

    wb_state_e state, state_nxt;
    wb_owner_e owner, owner_nxt;
    wb_owner_e last, last_nxt;

    logic             own_cyc;
    logic             own_stb;
    logic             own_we;
    logic [3:0]       own_sel;
    logic [ADR_W-1:0] own_adr;
    logic [DAT_W-1:0] own_dat_w;

    logic in_own;
    logic in_err;
    logic pick_m1;
    logic bus_ack;
    logic wd_clr;
    logic wd_inc;
    logic wd_expired;

    always_comb begin
        if (owner == OWNER_M1) begin
            own_cyc   = m1_cyc;
            own_stb   = m1_stb;
            own_we    = m1_we;
            own_sel   = m1_sel;
            own_adr   = m1_adr;
            own_dat_w = m1_dat_w;
        end else begin
            own_cyc   = m0_cyc;
            own_stb   = m0_stb;
            own_we    = m0_we;
            own_sel   = m0_sel;
            own_adr   = m0_adr;
            own_dat_w = m0_dat_w;
        end
    end

    // On a tie the master that did not win last time gets the bus.
    assign pick_m1 = m1_cyc & (~m0_cyc | (last == OWNER_M0));

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        case (state)
            ST_IDLE: begin
                if (m0_cyc || m1_cyc) begin
                    state_nxt = ST_OWN;
                    owner_nxt = pick_m1 ? OWNER_M1 : OWNER_M0;
                    last_nxt  = pick_m1 ? OWNER_M1 : OWNER_M0;
                end
            end
            ST_OWN: begin
                if (!own_cyc) begin
                    state_nxt = ST_IDLE;
                end else if (wd_expired) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                state_nxt = own_cyc ? ST_OWN : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
            owner <= OWNER_M0;
            last  <= OWNER_M1;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
        end
    end

    assign in_own = (state == ST_OWN);
    assign in_err = (state == ST_ERR);

    assign s_cyc   = in_own & own_cyc;
    assign s_stb   = in_own & own_cyc & own_stb;
    assign s_we    = in_own & own_we;
    assign s_sel   = in_own ? own_sel   : '0;
    assign s_adr   = in_own ? own_adr   : '0;
    assign s_dat_w = in_own ? own_dat_w : '0;

    // s_stb is already zero outside OWN, so a late ack in ERR cannot leak.
    assign bus_ack = s_ack & s_stb;

    assign m0_ack   = bus_ack & (owner == OWNER_M0);
    assign m1_ack   = bus_ack & (owner == OWNER_M1);
    assign m0_err   = in_err  & (owner == OWNER_M0);
    assign m1_err   = in_err  & (owner == OWNER_M1);
    assign m0_dat_r = (in_own && (owner == OWNER_M0)) ? s_dat_r : '0;
    assign m1_dat_r = (in_own && (owner == OWNER_M1)) ? s_dat_r : '0;

    assign grant = (in_own || in_err) ? {owner == OWNER_M1, owner == OWNER_M0} : 2'b00;

    assign wd_inc = s_stb & ~s_ack;
    assign wd_clr = ~in_own | ~s_stb | s_ack;

    newmot_wb_watchdog #(
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .clr     (wd_clr),
        .inc     (wd_inc),
        .expired (wd_expired)
    );

endmodule

// File: doc/newmot_wb_arbiter.md
# newmot_wb_arbiter

Two-master, one-slave Wishbone arbiter that shares the newmot register bus between the management SoC Wishbone port and the uartbone bridge. It sits between those two masters and the `top` Wishbone slave inside the wrapped design. Arbitration is round-robin and locked for the length of a bus cycle. A per-transfer watchdog terminates with an error any transfer the slave fails to acknowledge.

## Interface
Parameters:
- `ADR_W`, 30, word-address width (byte lanes already stripped).
- `DAT_W`, 32, data width.
- `TIMEOUT`, 255, number of unacknowledged strobe cycles before an error is forced; 0 disables the watchdog.

Ports:
- `sys_clk`  in  1  single clock for all logic.
- `sys_rst_n`  in  1  reset, synchronous, active-low.
- `m0_cyc`, `m0_stb`, `m0_we`  in  1 each  master 0 (management SoC) cycle, strobe and write enable.
- `m0_sel`  in  4  master 0 byte select.
- `m0_adr`  in  ADR_W  master 0 address.
- `m0_dat_w`  in  DAT_W  master 0 write data.
- `m0_dat_r`  out  DAT_W  master 0 read data.
- `m0_ack`, `m0_err`  out  1 each  master 0 termination.
- `m1_*`  same set as `m0_*`, for master 1 (uartbone).
- `s_cyc`, `s_stb`, `s_we`  out  1 each  slave cycle, strobe and write enable.
- `s_sel`  out  4  slave byte select.
- `s_adr`  out  ADR_W  slave address.
- `s_dat_w`  out  DAT_W  slave write data.
- `s_dat_r`  in  DAT_W  slave read data.
- `s_ack`  in  1  slave acknowledge.
- `grant`  out  2  one-hot current owner; 00 when idle.

## Operation
- States:
  - IDLE: no owner.
  - OWN: owner registered.
  - ERR: one-cycle forced termination.
- IDLE, no `m*_cyc` high: stay in IDLE.
- IDLE, one `m*_cyc` high: register that master as owner and go to OWN.
- IDLE, both `m*_cyc` high: grant the master that is not `last`. `last` is the owner of the most recent grant; its reset value is 1, so m0 wins the first tie.
- OWN:
  - `s_cyc = owner_cyc`.
  - `s_stb = owner_cyc & owner_stb`.
  - `s_we`, `s_sel`, `s_adr`, `s_dat_w` are muxed combinationally from the owner.
  - `owner_ack = s_ack & s_stb`.
  - `owner_dat_r = s_dat_r`.
- OWN with owner `cyc` low: go to IDLE. Ownership is never preempted while `cyc` is high, so multi-beat and back-to-back transfers inside one cycle stay locked.
- Watchdog:
  - Counter has width `$clog2(TIMEOUT+1)`.
  - It increments each OWN cycle with `s_stb` high and `s_ack` low.
  - It clears on `s_ack`, on `s_stb` low, and on leaving OWN.
  - When the counter equals TIMEOUT, go to ERR on the next edge.
- ERR, held for exactly one cycle:
  - `owner_err = 1` and `owner_ack = 0`.
  - `s_cyc = s_stb = 0`.
  - Next state is OWN if owner `cyc` is still high, otherwise IDLE.
  - A late `s_ack` arriving in ERR is ignored.
- Non-owner, or any master while in IDLE: `ack = err = 0` and `dat_r = 0`.
- All `s_*` outputs are 0 whenever the state is not OWN.
- `ack` and `err` are never asserted together on the same master.

## Timing
- Reset value of every output is 0, and `grant = 00`.
- Reset mid-transfer: on the first edge with `sys_rst_n` low, go to IDLE and set `last = 1`. The slave bus is dropped, and any in-flight `s_ack` is discarded.
- Arbitration latency: a request sampled in IDLE in cycle N produces `grant` and `s_cyc`/`s_stb` in cycle N+1.
- Acknowledge and read data pass combinationally from the slave to the owner with zero added latency.
- Release: owner `cyc` low in cycle N gives IDLE in N+1. A pending other master is granted in N+2.
- Watchdog: with `s_stb` held and no ack, `owner_err` pulses TIMEOUT+1 cycles after `s_stb` first rises.
- Simultaneous release and new request: handled in order, release to IDLE first, then arbitration on the next cycle.

## Structure
- Package `newmot_wb_pkg` contains:
  - the state enum (IDLE, OWN, ERR);
  - the owner encoding;
  - `NEWMOT_WB_TIMEOUT_DEFAULT = 255`;
  - the ADR_W/DAT_W defaults.
- Sub-module `newmot_wb_watchdog`: a parameterised saturating counter with `clr`/`inc` inputs and an `expired` output. It is instantiated once.

## Test plan
- Single m0 read at `adr=0x10`, slave acks with `0xA5A5A5A5` two cycles later -> `grant=01` one cycle after `cyc`; `m0_dat_r=0xA5A5A5A5` and `m0_ack` in the same cycle as `s_ack`; `m1_ack=0`.
- Both masters raise `cyc` in the same cycle from reset -> m0 granted first. After m0 drops `cyc`, `grant` goes 00 and then 10. On the next tie m0 wins again (`last=1`).
- m1 holds `cyc` across 3 back-to-back writes while m0 requests -> `grant` stays 10 for all 3 acks. m0 is granted 2 cycles after m1 drops `cyc`.
- TIMEOUT=4, slave never acks -> `m0_err` high exactly one cycle, 5 cycles after `s_stb` rises; `s_cyc=0` that cycle; `m0_ack` never asserts.
- `sys_rst_n` low for one cycle during an owned transfer -> next cycle all `s_*` are 0, `grant=00`, and an `s_ack` arriving then produces no `m*_ack`.
